dm_lane_tx_ctrl: RTL and testbench



---
 rtl/dm_lane_tx_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dm_lane_tx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lane_tx_ctrl.sv
// DM lane transmit controller: write-latency aligned DM serializer data with OE
// framing, plus an IOD output-delay tap stepping controller.
module dm_lane_tx_ctrl #(
    parameter int unsigned WL_MAX     = 7,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic       FAB_CLK,
    input  logic       ARST,
    input  logic       WR_VALID,
    input  logic [7:0] WR_DM,
    input  logic [2:0] WL_DLY,
    output logic [7:0] TX_DATA_0,
    output logic [3:0] OE_DATA_0,
    input  logic       TAP_REQ,
    input  logic [6:0] TAP_TARGET,
    input  logic       TAP_RELOAD,
    output logic       DELAY_LINE_MOVE_0,
    output logic       DELAY_LINE_DIRECTION_0,
    output logic       DELAY_LINE_LOAD_0,
    input  logic       DELAY_LINE_OUT_OF_RANGE_0,
    output logic       TAP_BUSY,
    output logic       TAP_DONE,
    output logic       TAP_ERR,
    output logic [6:0] TAP_CUR
);
    localparam int unsigned PIPE_D = (WL_MAX > 0) ? WL_MAX : 1;
    localparam int unsigned IDX_W  = (PIPE_D > 1) ? $clog2(PIPE_D) : 1;
    localparam int unsigned CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_SETTLE,
        S_DONE,
        S_ERR
    } tap_state_t;

    logic [2:0]        wl_q;
    logic [2:0]        wl_in;
    logic [PIPE_D-1:0] vld_q;
    logic [7:0]        dm_q [PIPE_D];
    logic              tx_vld_q;
    logic              nxt_vld;
    logic [7:0]        nxt_dm;
    logic              look_vld;

    tap_state_t        state_q;
    logic [6:0]        target_q;
    logic [CNT_W-1:0]  cnt_q;

    assign wl_in = (32'(WL_DLY) > WL_MAX) ? 3'(WL_MAX) : WL_DLY;

    // Beat landing on TX next cycle, and the beat one cycle behind it (preamble
    // lookahead). With zero delay there is no earlier copy, so no preamble.
    always_comb begin
        nxt_vld  = WR_VALID;
        nxt_dm   = WR_DM;
        look_vld = 1'b0;
        if (wl_q != 3'd0) begin
            nxt_vld = vld_q[IDX_W'(wl_q - 3'd1)];
            nxt_dm  = dm_q[IDX_W'(wl_q - 3'd1)];
        end
        if (wl_q == 3'd1) begin
            look_vld = WR_VALID;
        end else if (wl_q >= 3'd2) begin
            look_vld = vld_q[IDX_W'(wl_q - 3'd2)];
        end
    end

    // Delay pipe; stages at or beyond the active depth are cleared so a later
    // latency increase never replays stale beats.
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            wl_q      <= 3'd0;
            vld_q     <= '0;
            tx_vld_q  <= 1'b0;
            TX_DATA_0 <= 8'h00;
            OE_DATA_0 <= 4'h0;
            for (int k = 0; k < PIPE_D; k++) begin
                dm_q[k] <= 8'h00;
            end
        end else begin
            if (!WR_VALID && (vld_q == '0)) begin
                wl_q <= wl_in;
            end
            vld_q[0] <= WR_VALID && (wl_q != 3'd0);
            dm_q[0]  <= WR_DM;
            for (int k = 1; k < PIPE_D; k++) begin
                vld_q[k] <= vld_q[k-1] && (32'(wl_q) > 32'(k));
                dm_q[k]  <= dm_q[k-1];
            end
            tx_vld_q  <= nxt_vld;
            TX_DATA_0 <= nxt_vld ? nxt_dm : 8'h00;
            // Postamble | beat | preamble; gaps of up to two idle cycles close up.
            OE_DATA_0 <= (tx_vld_q || nxt_vld || look_vld) ? 4'hF : 4'h0;
        end
    end

    // Tap controller: pulses are set on the transition into the state that owns them.
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q                <= S_IDLE;
            target_q               <= 7'd0;
            cnt_q                  <= '0;
            TAP_CUR                <= 7'd1;
            DELAY_LINE_MOVE_0      <= 1'b0;
            DELAY_LINE_DIRECTION_0 <= 1'b0;
            DELAY_LINE_LOAD_0      <= 1'b0;
            TAP_BUSY               <= 1'b0;
            TAP_DONE               <= 1'b0;
            TAP_ERR                <= 1'b0;
        end else begin
            DELAY_LINE_MOVE_0 <= 1'b0;
            DELAY_LINE_LOAD_0 <= 1'b0;
            TAP_DONE          <= 1'b0;
            TAP_ERR           <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (TAP_REQ) begin
                        target_q <= TAP_TARGET;
                        if (TAP_RELOAD) begin
                            state_q           <= S_LOAD;
                            DELAY_LINE_LOAD_0 <= 1'b1;
                            TAP_BUSY          <= 1'b1;
                        end else if (TAP_TARGET == TAP_CUR) begin
                            state_q  <= S_DONE;
                            TAP_DONE <= 1'b1;
                        end else begin
                            state_q                <= S_STEP;
                            DELAY_LINE_DIRECTION_0 <= (TAP_TARGET > TAP_CUR);
                            TAP_BUSY               <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    TAP_CUR <= 7'd1;
                    if (target_q == 7'd1) begin
                        state_q  <= S_DONE;
                        TAP_DONE <= 1'b1;
                        TAP_BUSY <= 1'b0;
                    end else begin
                        state_q                <= S_STEP;
                        DELAY_LINE_DIRECTION_0 <= (target_q > 7'd1);
                    end
                end
                S_STEP: begin
                    DELAY_LINE_MOVE_0 <= 1'b1;
                    TAP_CUR           <= DELAY_LINE_DIRECTION_0 ? (TAP_CUR + 7'd1) : (TAP_CUR - 7'd1);
                    cnt_q             <= '0;
                    state_q           <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (DELAY_LINE_OUT_OF_RANGE_0) begin
                        state_q  <= S_ERR;
                        TAP_ERR  <= 1'b1;
                        TAP_BUSY <= 1'b0;
                    end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        if (TAP_CUR == target_q) begin
                            state_q  <= S_DONE;
                            TAP_DONE <= 1'b1;
                            TAP_BUSY <= 1'b0;
                        end else begin
                            state_q                <= S_STEP;
                            DELAY_LINE_DIRECTION_0 <= (target_q > TAP_CUR);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE, S_ERR: state_q <= S_IDLE;
                default:       state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dm_lane_tx_ctrl.sv
// Bench for dm_lane_tx_ctrl: data-path vector table with a beat scoreboard,
// plus hand sequences for tap stepping, range error and reset abort.
module tb_dm_lane_tx_ctrl;
    localparam int unsigned SETTLE_CYC = 3;
    localparam int NV = 6;

    logic       fab_clk = 1'b0;
    logic       arst;
    logic       wr_valid;
    logic [7:0] wr_dm;
    logic [2:0] wl_dly;
    logic [7:0] tx_data;
    logic [3:0] oe_data;
    logic       tap_req;
    logic [6:0] tap_target;
    logic       tap_reload;
    logic       dl_move, dl_dir, dl_load, dl_oor;
    logic       tap_busy, tap_done, tap_err;
    logic [6:0] tap_cur;

    typedef struct packed {
        logic [2:0]  wl;
        logic [7:0]  vmask;
        logic [63:0] dm;
        logic [15:0] oe_cyc;
    } dvec_t;

    typedef struct packed {
        logic [31:0] due;
        logic [7:0]  dm;
    } sb_t;

    dvec_t      vecs [NV];
    int         n_vec = 0;
    int         n_miss = 0;
    logic [6:0] mcur;
    int         loads, moves, dones, errs, bad_dir, bad_gap;
    logic       busy1;
    int         cnt_a, cnt_b;
    logic       seen;

    dm_lane_tx_ctrl #(.WL_MAX(7), .SETTLE_CYC(SETTLE_CYC)) dut (
        .FAB_CLK(fab_clk),
        .ARST(arst),
        .WR_VALID(wr_valid),
        .WR_DM(wr_dm),
        .WL_DLY(wl_dly),
        .TX_DATA_0(tx_data),
        .OE_DATA_0(oe_data),
        .TAP_REQ(tap_req),
        .TAP_TARGET(tap_target),
        .TAP_RELOAD(tap_reload),
        .DELAY_LINE_MOVE_0(dl_move),
        .DELAY_LINE_DIRECTION_0(dl_dir),
        .DELAY_LINE_LOAD_0(dl_load),
        .DELAY_LINE_OUT_OF_RANGE_0(dl_oor),
        .TAP_BUSY(tap_busy),
        .TAP_DONE(tap_done),
        .TAP_ERR(tap_err),
        .TAP_CUR(tap_cur)
    );

    always #5 fab_clk = ~fab_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_dvec(input dvec_t v, input int idx);
        sb_t        sbq[$];
        sb_t        e;
        logic [7:0] exp_tx;
        @(posedge fab_clk); #1;
        wl_dly   = v.wl;
        wr_valid = 1'b0;
        repeat (3) @(posedge fab_clk);
        for (int c = 0; c < 16; c++) begin
            @(posedge fab_clk); #1;
            wr_valid = (c < 8) ? v.vmask[c] : 1'b0;
            wr_dm    = (c < 8) ? v.dm[8*c +: 8] : 8'h00;
            if (wr_valid) begin
                e.due = 32'(c + 1 + int'(v.wl));
                e.dm  = wr_dm;
                sbq.push_back(e);
            end
            @(negedge fab_clk);
            exp_tx = 8'h00;
            if (sbq.size() > 0 && sbq[0].due == 32'(c)) begin
                e = sbq.pop_front();
                exp_tx = e.dm;
            end
            check($sformatf("v%0d.tx c%0d", idx, c), 32'(tx_data), 32'(exp_tx));
            check($sformatf("v%0d.oe c%0d", idx, c), 32'(oe_data), v.oe_cyc[c] ? 32'hF : 32'h0);
        end
        check($sformatf("v%0d.sb_left", idx), 32'(sbq.size()), 32'd0);
    endtask

    task automatic run_tap(input logic [6:0] tgt, input logic rel, input int oor_after, input logic spur,
                           output int o_loads, output int o_moves, output int o_dones, output int o_errs,
                           output int o_bad_dir, output int o_bad_gap, output logic o_busy1);
        int   last_move = 0;
        logic dir_prev  = 1'b0;
        bit   fin       = 1'b0;
        o_loads = 0; o_moves = 0; o_dones = 0; o_errs = 0; o_bad_dir = 0; o_bad_gap = 0; o_busy1 = 1'b0;
        @(posedge fab_clk); #1;
        tap_req = 1'b1; tap_target = tgt; tap_reload = rel;
        @(posedge fab_clk); #1;
        tap_req = 1'b0;
        if (rel) mcur = 7'd1;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(negedge fab_clk);
            if (k == 0) o_busy1 = tap_busy;
            if (dl_load) o_loads++;
            if (dl_move) begin
                o_moves++;
                if (dl_dir !== (tgt > mcur)) o_bad_dir++;
                if (dir_prev !== dl_dir) o_bad_dir++;
                if (o_moves > 1 && (k - last_move) != int'(SETTLE_CYC) + 1) o_bad_gap++;
                last_move = k;
                mcur = (tgt > mcur) ? mcur + 7'd1 : mcur - 7'd1;
                if (oor_after > 0 && o_moves == oor_after) dl_oor = 1'b1;
            end
            dir_prev = dl_dir;
            if (tap_done) o_dones++;
            if (tap_err) o_errs++;
            if (tap_done || tap_err) fin = 1'b1;
            if (spur && k == 2) begin
                tap_req = 1'b1; tap_target = 7'd100; tap_reload = 1'b0;
            end else begin
                tap_req = 1'b0;
            end
        end
        tap_req = 1'b0;
        if (!fin) check("tap.timeout", 32'd0, 32'd1);
        repeat (6) begin
            @(negedge fab_clk);
            if (dl_move) o_moves++;
            if (tap_done) o_dones++;
            if (tap_err) o_errs++;
        end
    endtask

    initial begin
        vecs[0] = '{wl: 3'd2, vmask: 8'b0000_1111, dm: 64'h0000_0000_00FF_5AA5, oe_cyc: 16'h00FC};
        vecs[1] = '{wl: 3'd2, vmask: 8'b0000_1001, dm: 64'h0000_0000_C300_003C, oe_cyc: 16'h00FC};
        vecs[2] = '{wl: 3'd1, vmask: 8'b0000_0011, dm: 64'h0000_0000_0000_2211, oe_cyc: 16'h001E};
        vecs[3] = '{wl: 3'd4, vmask: 8'b0001_0001, dm: 64'h0000_0096_0000_003C, oe_cyc: 16'h0770};
        vecs[4] = '{wl: 3'd7, vmask: 8'b0000_0001, dm: 64'h0000_0000_0000_00E7, oe_cyc: 16'h0380};
        vecs[5] = '{wl: 3'd3, vmask: 8'b0000_0101, dm: 64'h0000_0000_0080_0001, oe_cyc: 16'h00F8};

        arst = 1'b1; wr_valid = 1'b0; wr_dm = 8'h00; wl_dly = 3'd2;
        tap_req = 1'b0; tap_target = 7'd0; tap_reload = 1'b0; dl_oor = 1'b0; mcur = 7'd1;
        repeat (3) @(negedge fab_clk);
        check("rst.tx", 32'(tx_data), 32'h0);
        check("rst.oe", 32'(oe_data), 32'h0);
        check("rst.ctl", {29'd0, dl_move, dl_dir, dl_load}, 32'h0);
        check("rst.stat", {29'd0, tap_busy, tap_done, tap_err}, 32'h0);
        check("rst.cur", 32'(tap_cur), 32'd1);
        arst = 1'b0;

        // Data vectors with a concurrent tap move that must not disturb them.
        fork
            begin
                for (int i = 0; i < NV; i++) run_dvec(vecs[i], i);
            end
            begin
                run_tap(7'd3, 1'b1, 0, 1'b0, loads, moves, dones, errs, bad_dir, bad_gap, busy1);
            end
        join
        check("bg.moves", 32'(moves), 32'd2);
        check("bg.cur", 32'(tap_cur), 32'd3);

        // Latency change while a beat is in flight only takes effect once drained.
        @(posedge fab_clk); #1; wl_dly = 3'd2;
        repeat (3) @(posedge fab_clk);
        for (int c = 0; c < 15; c++) begin
            @(posedge fab_clk); #1;
            wr_valid = (c == 0 || c == 5);
            wr_dm    = (c == 0) ? 8'h5E : ((c == 5) ? 8'h6F : 8'h00);
            if (c == 1) wl_dly = 3'd5;
            @(negedge fab_clk);
            check($sformatf("wlchg.tx c%0d", c), 32'(tx_data),
                  (c == 3) ? 32'h5E : ((c == 11) ? 32'h6F : 32'h0));
            check($sformatf("wlchg.oe c%0d", c), 32'(oe_data),
                  (c inside {2, 3, 4, 10, 11, 12}) ? 32'hF : 32'h0);
        end

        // Reload to 5 with a spurious request injected while busy.
        run_tap(7'd5, 1'b1, 0, 1'b1, loads, moves, dones, errs, bad_dir, bad_gap, busy1);
        check("up.loads", 32'(loads), 32'd1);
        check("up.moves", 32'(moves), 32'd4);
        check("up.dir", 32'(bad_dir), 32'd0);
        check("up.gap", 32'(bad_gap), 32'd0);
        check("up.done", 32'(dones), 32'd1);
        check("up.err", 32'(errs), 32'd0);
        check("up.busy1", 32'(busy1), 32'd1);
        check("up.cur", 32'(tap_cur), 32'd5);
        check("up.busy_end", 32'(tap_busy), 32'd0);

        run_tap(7'd2, 1'b0, 0, 1'b0, loads, moves, dones, errs, bad_dir, bad_gap, busy1);
        check("dn.loads", 32'(loads), 32'd0);
        check("dn.moves", 32'(moves), 32'd3);
        check("dn.dir", 32'(bad_dir), 32'd0);
        check("dn.gap", 32'(bad_gap), 32'd0);
        check("dn.done", 32'(dones), 32'd1);
        check("dn.cur", 32'(tap_cur), 32'd2);

        run_tap(7'd2, 1'b0, 0, 1'b0, loads, moves, dones, errs, bad_dir, bad_gap, busy1);
        check("same.moves", 32'(moves), 32'd0);
        check("same.done", 32'(dones), 32'd1);
        check("same.cur", 32'(tap_cur), 32'd2);

        run_tap(7'd6, 1'b1, 2, 1'b0, loads, moves, dones, errs, bad_dir, bad_gap, busy1);
        dl_oor = 1'b0;
        check("oor.moves", 32'(moves), 32'd2);
        check("oor.err", 32'(errs), 32'd1);
        check("oor.done", 32'(dones), 32'd0);
        check("oor.cur", 32'(tap_cur), 32'd3);
        check("oor.busy", 32'(tap_busy), 32'd0);

        // Reset during SETTLE with a burst running.
        @(posedge fab_clk); #1; wl_dly = 3'd1;
        repeat (3) @(posedge fab_clk);
        #1;
        wr_valid = 1'b1; wr_dm = 8'hFF;
        tap_req = 1'b1; tap_target = 7'd9; tap_reload = 1'b1;
        @(posedge fab_clk); #1;
        tap_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge fab_clk);
            if (dl_move) seen = 1'b1;
        end
        check("rst2.move_seen", 32'(seen), 32'd1);
        tap_req = 1'b1; tap_target = 7'd0; tap_reload = 1'b0;
        @(posedge fab_clk); #1;
        tap_req = 1'b0;
        check("rst2.pre_tx", 32'(tx_data), 32'hFF);
        #2; arst = 1'b1; #1;
        check("rst2.tx", 32'(tx_data), 32'h0);
        check("rst2.oe", 32'(oe_data), 32'h0);
        check("rst2.ctl", {29'd0, dl_move, dl_dir, dl_load}, 32'h0);
        check("rst2.stat", {29'd0, tap_busy, tap_done, tap_err}, 32'h0);
        check("rst2.cur", 32'(tap_cur), 32'd1);
        wr_valid = 1'b0;
        repeat (2) @(posedge fab_clk);
        @(negedge fab_clk);
        arst = 1'b0;
        mcur = 7'd1;
        cnt_a = 0; cnt_b = 0;
        repeat (20) begin
            @(negedge fab_clk);
            if (dl_move) cnt_a++;
            if (tap_busy || tap_done) cnt_b++;
        end
        check("rst2.no_move", 32'(cnt_a), 32'd0);
        check("rst2.idle", 32'(cnt_b), 32'd0);
        check("rst2.cur_after", 32'(tap_cur), 32'd1);

        run_tap(7'd2, 1'b1, 0, 1'b0, loads, moves, dones, errs, bad_dir, bad_gap, busy1);
        check("post.loads", 32'(loads), 32'd1);
        check("post.moves", 32'(moves), 32'd1);
        check("post.done", 32'(dones), 32'd1);
        check("post.cur", 32'(tap_cur), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
